keypad_scanner: RTL

Hardware matrix-keypad scanner that replaces software PIO row/column polling of the display-board keypad. Drives one row at a time with open-drain active-low drive and samples the pulled-up column inputs. Debounces every key and pushes press/release events into an event FIFO for the Nios CPU to read. Sits between the GPIO header pins and an Avalon-facing PIO/register wrapper, in the CPU clock domain.

---
 rtl/keypad_pkg.sv | 27 ++
 rtl/keypad_evt_fifo.sv | 68 ++++++
 rtl/keypad_scanner.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and event-word layout for the matrix keypad scanner.
// The event word is {press, row, col}: col in the LSBs, press in the MSB.
package keypad_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_DRIVE  = 3'd1,
        ST_SAMPLE = 3'd2,
        ST_EVAL   = 3'd3,
        ST_NEXT   = 3'd4
    } scan_state_e;

    localparam int EVT_COL_LSB = 0;

    function automatic int evt_w(input int rows, input int cols);
        return 1 + $clog2(rows) + $clog2(cols);
    endfunction

    function automatic int evt_row_lsb(input int cols);
        return EVT_COL_LSB + $clog2(cols);
    endfunction

    function automatic int evt_press_pos(input int rows, input int cols);
        return evt_row_lsb(cols) + $clog2(rows);
    endfunction

endpackage

// File: rtl/keypad_evt_fifo.sv
// Single-clock FIFO with a registered head word, simultaneous push/pop, and
// drop-on-full that reports the dropped push as a one-cycle ovf_o pulse.
module keypad_evt_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic             clk,
    input  logic             srst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] push_data_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] head_o,
    output logic             empty_o,
    output logic             full_o,
    output logic             ovf_o
);
    localparam int AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_q, wr_ptr_d;
    logic [AW:0]      rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] head_q, head_d;
    logic             push_fire, pop_fire;

    assign empty_o = (wr_ptr_q == rd_ptr_q);
    assign full_o  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);

    // A pop frees a slot in the same cycle, so push+pop is accepted even when full.
    assign pop_fire  = pop_i & ~empty_o;
    assign push_fire = push_i & (~full_o | pop_fire);
    assign ovf_o     = push_i & full_o & ~pop_fire;

    assign head_o = head_q;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (AW+1)'(push_fire);
        rd_ptr_d = rd_ptr_q + (AW+1)'(pop_fire);
        // The new head is being written this cycle only when the FIFO is
        // (or becomes) empty apart from the incoming word.
        if (push_fire && (wr_ptr_q[AW-1:0] == rd_ptr_d[AW-1:0])) begin
            head_d = push_data_i;
        end else begin
            head_d = mem_q[rd_ptr_d[AW-1:0]];
        end
    end

    always_ff @(posedge clk) begin
        if (srst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            head_q   <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            if (push_fire || pop_fire) begin
                head_q <= head_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (push_fire) begin
            mem_q[wr_ptr_q[AW-1:0]] <= push_data_i;
        end
    end

endmodule

// File: rtl/keypad_scanner.sv
// Matrix keypad scanner: one row driven at a time, 2-FF column sync, per-key
// debounce, press/release events queued in a FIFO. Option: KEYPAD_GHOST_BLOCK_EN.
module keypad_scanner
    import keypad_pkg::*;
#(
    parameter int ROWS       = 4,
    parameter int COLS       = 5,
    parameter int SETTLE_CYC = 64,
    parameter int DEB_SCANS  = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                         iCLK,
    input  logic                         iRST,
    input  logic                         iEN,
    input  logic [COLS-1:0]              iCOL_N,
    output logic [ROWS-1:0]              oROW_OE,
    output logic [evt_w(ROWS, COLS)-1:0] oEVT_DATA,
    output logic                         oEVT_VALID,
    input  logic                         iEVT_READY,
    output logic [ROWS*COLS-1:0]         oKEYS,
    output logic                         oOVF,
    input  logic                         iOVF_CLR
);
    localparam int RW        = $clog2(ROWS);
    localparam int CW        = $clog2(COLS);
    localparam int NK        = ROWS * COLS;
    localparam int KW        = $clog2(NK);
    localparam int SW        = $clog2(SETTLE_CYC);
    localparam int DW        = 4;
    localparam int EW        = evt_w(ROWS, COLS);
    localparam int PRESS_POS = evt_press_pos(ROWS, COLS);
    localparam int ROW_LSB   = evt_row_lsb(COLS);

    scan_state_e     state_q, state_d;
    logic [RW-1:0]   row_q, row_d;
    logic [CW-1:0]   col_q, col_d;
    logic [SW-1:0]   settle_q, settle_d;
    logic [COLS-1:0] sample_q, sample_d;
    logic [COLS-1:0] col_meta_q, col_sync_q;
    logic [NK-1:0]   keys_q;
    logic [DW-1:0]   cnt_q [NK];
    logic            ovf_q;

    logic            eval_en;
    logic            row_drive;
    logic [KW-1:0]   key_idx;
    logic            cur_stable, cur_sample;
    logic [DW-1:0]   cur_cnt, cnt_inc;
    logic            stable_d;
    logic [DW-1:0]   cnt_d;
    logic            evt_push;
    logic [EW-1:0]   evt_word;
    logic            ghost;
    logic            fifo_empty, fifo_ovf, fifo_full_unused;

    // Column pins are asynchronous; idle (released) level is high.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            col_meta_q <= '1;
            col_sync_q <= '1;
        end else begin
            col_meta_q <= iCOL_N;
            col_sync_q <= col_meta_q;
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            state_q  <= ST_IDLE;
            row_q    <= '0;
            col_q    <= '0;
            settle_q <= '0;
            sample_q <= '0;
        end else begin
            state_q  <= state_d;
            row_q    <= row_d;
            col_q    <= col_d;
            settle_q <= settle_d;
            sample_q <= sample_d;
        end
    end

    // iEN is only consulted in IDLE and NEXT, so a started row always finishes.
    always_comb begin
        state_d  = state_q;
        row_d    = row_q;
        col_d    = col_q;
        settle_d = settle_q;
        sample_d = sample_q;
        eval_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                settle_d = '0;
                if (iEN) begin
                    state_d = ST_DRIVE;
                end
            end
            ST_DRIVE: begin
                if (settle_q == SW'(SETTLE_CYC - 1)) begin
                    settle_d = '0;
                    state_d  = ST_SAMPLE;
                end else begin
                    settle_d = settle_q + SW'(1);
                end
            end
            ST_SAMPLE: begin
                sample_d = ~col_sync_q;
                col_d    = '0;
                state_d  = ST_EVAL;
            end
            ST_EVAL: begin
                eval_en = 1'b1;
                if (col_q == CW'(COLS - 1)) begin
                    state_d = ST_NEXT;
                end else begin
                    col_d = col_q + CW'(1);
                end
            end
            ST_NEXT: begin
                row_d   = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
                state_d = iEN ? ST_DRIVE : ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign row_drive = (state_q == ST_DRIVE) || (state_q == ST_SAMPLE) ||
                       (state_q == ST_EVAL);

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_row_oe
        assign oROW_OE[gi] = row_drive && (row_q == RW'(gi));
    end

`ifdef KEYPAD_GHOST_BLOCK_EN
    // A press completes a ghost rectangle when both its row and its column
    // already hold a pressed key; the key itself is still 0 at that point.
    logic [COLS-1:0] row_keys [ROWS];
    logic [ROWS-1:0] col_keys;

    for (genvar gi = 0; gi < ROWS; gi++) begin : g_ghost
        assign row_keys[gi] = keys_q[gi*COLS +: COLS];
        assign col_keys[gi] = row_keys[gi][col_q];
    end

    assign ghost = (|row_keys[row_q]) && (|col_keys);
`else
    assign ghost = 1'b0;
`endif

    always_comb begin
        key_idx    = KW'(row_q) * KW'(COLS) + KW'(col_q);
        cur_stable = keys_q[key_idx];
        cur_cnt    = cnt_q[key_idx];
        cur_sample = sample_q[col_q];
        cnt_inc    = cur_cnt + DW'(1);
        stable_d   = cur_stable;
        cnt_d      = '0;
        evt_push   = 1'b0;
        if (cur_sample != cur_stable) begin
            if (cnt_inc == DW'(DEB_SCANS)) begin
                if (ghost && !cur_stable) begin
                    // Hold one short of qualifying so the press re-qualifies next scan.
                    cnt_d = DW'(DEB_SCANS - 1);
                end else begin
                    stable_d = ~cur_stable;
                    evt_push = eval_en;
                end
            end else begin
                cnt_d = cnt_inc;
            end
        end
    end

    always_ff @(posedge iCLK) begin
        if (iRST) begin
            keys_q <= '0;
            for (int i = 0; i < NK; i++) begin
                cnt_q[i] <= '0;
            end
        end else if (eval_en) begin
            keys_q[key_idx] <= stable_d;
            cnt_q[key_idx]  <= cnt_d;
        end
    end

    always_comb begin
        evt_word                        = '0;
        evt_word[PRESS_POS]             = stable_d;
        evt_word[ROW_LSB +: RW]         = row_q;
        evt_word[EVT_COL_LSB +: CW]     = col_q;
    end

    keypad_evt_fifo #(
        .WIDTH (EW),
        .DEPTH (FIFO_DEPTH)
    ) u_evt_fifo (
        .clk         (iCLK),
        .srst        (iRST),
        .push_i      (evt_push),
        .push_data_i (evt_word),
        .pop_i       (iEVT_READY),
        .head_o      (oEVT_DATA),
        .empty_o     (fifo_empty),
        .full_o      (fifo_full_unused),
        .ovf_o       (fifo_ovf)
    );

    // Set has priority over clear so a same-cycle drop is never lost.
    always_ff @(posedge iCLK) begin
        if (iRST) begin
            ovf_q <= 1'b0;
        end else if (fifo_ovf) begin
            ovf_q <= 1'b1;
        end else if (iOVF_CLR) begin
            ovf_q <= 1'b0;
        end
    end

    assign oEVT_VALID = ~fifo_empty;
    assign oKEYS      = keys_q;
    assign oOVF       = ovf_q;

endmodule
